// File: rtl/truth_table_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_checker_if
// Brief    : Stimulus/response and result bundle of the truth-table checker.
// Revision : 1.0 - initial release
// ============================================================================
interface truth_table_checker_if #(
    parameter int N_IN = 2
);
    logic                  start;
    logic                  s_in;
    logic [N_IN-1:0]       x;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [(2**N_IN)-1:0]  fail_mask;
    logic [N_IN:0]         fail_count;
    logic [N_IN-1:0]       minterm;

    modport master (
        input  start, s_in,
        output x, busy, done, pass, fail_mask, fail_count, minterm
    );

    modport slave (
        output start, s_in,
        input  x, busy, done, pass, fail_mask, fail_count, minterm
    );
endinterface
`default_nettype wire

// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_checker
// Brief    : Sweeps all minterms of a small gate, compares its output against
//            EXPECT and reports pass/fail. TT_CHECKER_STOP_ON_FAIL_EN ends the
//            sweep at the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_checker #(
    parameter int                  N_IN   = 2,
    parameter logic [2**N_IN-1:0]  EXPECT = 4'b0110,
    parameter int                  SETTLE = 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    truth_table_checker_if.master bus
);
    localparam int c_m      = 2**N_IN;
    localparam int c_wait_w = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(SETTLE - 1);
    localparam logic [N_IN-1:0]     c_last_mt   = N_IN'(c_m - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic [c_wait_w-1:0] wait_cnt_q,   wait_cnt_d;
    logic [N_IN-1:0]     minterm_q,    minterm_d;
    logic [c_m-1:0]      fail_mask_q,  fail_mask_d;
    logic [N_IN:0]       fail_count_q, fail_count_d;
    logic [N_IN-1:0]     x_q,          x_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                pass_q,       pass_d;
    logic                w_mismatch;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        minterm_d    = minterm_q;
        fail_mask_d  = fail_mask_q;
        fail_count_d = fail_count_q;
        w_mismatch   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d      = ST_DRIVE;
                    wait_cnt_d   = '0;
                    minterm_d    = '0;
                    fail_mask_d  = '0;
                    fail_count_d = '0;
                end
            end
            ST_DRIVE: begin
                if (wait_cnt_q == c_wait_last) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_mismatch = (bus.s_in != EXPECT[minterm_q]);
                if (w_mismatch) begin
                    fail_mask_d[minterm_q] = 1'b1;
                    fail_count_d           = fail_count_q + 1'b1;
                end
`ifdef TT_CHECKER_STOP_ON_FAIL_EN
                if (w_mismatch || (minterm_q == c_last_mt)) begin
`else
                if (minterm_q == c_last_mt) begin
`endif
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_DRIVE;
                    minterm_d  = minterm_q + 1'b1;
                    wait_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from next state so they are plain flops; x only
        // moves when minterm_d does, i.e. on the DRIVE entry edge.
        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (fail_mask_d == '0);
        x_d    = busy_d ? minterm_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            minterm_q    <= '0;
            fail_mask_q  <= '0;
            fail_count_q <= '0;
            x_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            minterm_q    <= minterm_d;
            fail_mask_q  <= fail_mask_d;
            fail_count_q <= fail_count_d;
            x_q          <= x_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign bus.x          = x_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_mask  = fail_mask_q;
    assign bus.fail_count = fail_count_q;
    assign bus.minterm    = minterm_q;
endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_checker
// Brief    : Scoreboard bench; stimulus queues expected sweep results, a
//            negedge monitor compares them when done rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;
    logic clk = 1'b0;
    logic reset;
    int   mode0;

    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(2)) if0 ();
    truth_table_checker_if #(.N_IN(2)) if1 ();

    truth_table_checker #(.N_IN(2), .EXPECT(4'b0110), .SETTLE(1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.master)
    );

    truth_table_checker #(.N_IN(2), .EXPECT(4'b0110), .SETTLE(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.master)
    );

    // Gate models: 0 = XOR, 1 = ~a & b (faulty), otherwise stuck at 1
    assign if0.s_in = (mode0 == 0) ? (if0.x[1] ^ if0.x[0]) :
                      (mode0 == 1) ? (~if0.x[1] & if0.x[0]) : 1'b1;
    assign if1.s_in = 1'b1;

    typedef struct {
        logic       pass;
        logic [3:0] mask;
        logic [2:0] count;
        logic [1:0] mt;
        int         lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;

    int   m_idx[2]       = '{0, 0};
    logic m_busy_prev[2] = '{1'b0, 1'b0};
    logic m_done_prev[2] = '{1'b0, 1'b0};
    logic m_xerr[2]      = '{1'b0, 1'b0};

    function automatic exp_t mk(input logic p, input logic [3:0] m,
                                input logic [2:0] c, input logic [1:0] t, input int l);
        exp_t e;
        e.pass = p; e.mask = m; e.count = c; e.mt = t; e.lat = l;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic mon(input int w, input int settle, input logic busy, input logic done,
                       input logic pass, input logic [1:0] x, input logic [3:0] mask,
                       input logic [2:0] cnt, input logic [1:0] mt);
        int   idx;
        exp_t e;
        logic have;
        idx = (busy && !m_busy_prev[w]) ? 0 : m_idx[w];
        if (busy && !m_busy_prev[w]) m_xerr[w] = 1'b0;
        if (busy && (int'(x) != idx / (settle + 1))) m_xerr[w] = 1'b1;
        m_idx[w] = idx + 1;
        if (done && !m_done_prev[w]) begin
            have = (w == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL dut%0d unexpected_done: actual=1 required=0", w);
            end else begin
                e = (w == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dut%0d pass", w),       int'(pass), int'(e.pass));
                chk($sformatf("dut%0d fail_mask", w),  int'(mask), int'(e.mask));
                chk($sformatf("dut%0d fail_count", w), int'(cnt),  int'(e.count));
                chk($sformatf("dut%0d minterm", w),    int'(mt),   int'(e.mt));
                chk($sformatf("dut%0d latency", w),    idx,        e.lat);
                chk($sformatf("dut%0d x_seq_err", w),  int'(m_xerr[w]), 0);
            end
        end
        m_busy_prev[w] = busy;
        m_done_prev[w] = done;
    endtask

    always @(negedge clk) begin
        mon(0, 1, if0.busy, if0.done, if0.pass, if0.x, if0.fail_mask, if0.fail_count, if0.minterm);
        mon(1, 3, if1.busy, if1.done, if1.pass, if1.x, if1.fail_mask, if1.fail_count, if1.minterm);
    end

    task automatic drain(input int w);
        for (int i = 0; i < 100; i++) begin
            if (((w == 0) ? q0.size() : q1.size()) == 0) break;
            @(negedge clk);
        end
        if (((w == 0) ? q0.size() : q1.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d done_timeout: actual=0 required=1", w);
            if (w == 0) q0.delete(); else q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic pulse0();
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, " x"},          int'(if0.x),          0);
        chk({tag, " busy"},       int'(if0.busy),       0);
        chk({tag, " done"},       int'(if0.done),       0);
        chk({tag, " pass"},       int'(if0.pass),       0);
        chk({tag, " fail_mask"},  int'(if0.fail_mask),  0);
        chk({tag, " fail_count"}, int'(if0.fail_count), 0);
        chk({tag, " minterm"},    int'(if0.minterm),    0);
    endtask

    exp_t e_pass;
    exp_t e_fault;
    exp_t e_stuck;

    initial begin
        e_pass = mk(1'b1, 4'b0000, 3'd0, 2'd3, 8);
`ifdef TT_CHECKER_STOP_ON_FAIL_EN
        e_fault = mk(1'b0, 4'b0100, 3'd1, 2'd2, 6);
        e_stuck = mk(1'b0, 4'b0001, 3'd1, 2'd0, 4);
`else
        e_fault = mk(1'b0, 4'b0100, 3'd1, 2'd3, 8);
        e_stuck = mk(1'b0, 4'b1001, 3'd2, 2'd3, 16);
`endif
        reset     = 1'b1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        mode0     = 0;
        repeat (3) @(negedge clk);
        chk_reset0("rst");
        chk("rst dut3 busy",      int'(if1.busy),      0);
        chk("rst dut3 done",      int'(if1.done),      0);
        chk("rst dut3 fail_mask", int'(if1.fail_mask), 0);
        reset = 1'b0;
        @(negedge clk);

        // Correct XOR gate
        q0.push_back(e_pass);
        pulse0();
        drain(0);

        // start re-asserted at cycle 3 of a sweep is ignored
        q0.push_back(e_pass);
        pulse0();
        repeat (2) @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        drain(0);

        // Faulty gate ~a & b
        mode0 = 1;
        q0.push_back(e_fault);
        pulse0();
        drain(0);

        // start while in DONE clears results on the accepting edge
        mode0 = 0;
        q0.push_back(e_pass);
        pulse0();
        chk("restart done",       int'(if0.done),       0);
        chk("restart busy",       int'(if0.busy),       1);
        chk("restart fail_mask",  int'(if0.fail_mask),  0);
        chk("restart fail_count", int'(if0.fail_count), 0);
        drain(0);

        // Reset at cycle 5 of a failing sweep, then a full sweep
        mode0 = 1;
        pulse0();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset0("abort");
        q0.push_back(e_fault);
        pulse0();
        drain(0);

        // Reset and start together in IDLE
        reset = 1'b1;
        @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        chk("rst_start busy", int'(if0.busy), 0);
        chk("rst_start done", int'(if0.done), 0);
        reset     = 1'b0;
        if0.start = 1'b0;
        @(negedge clk);

        // Stuck-at-1 gate with SETTLE = 3
        q1.push_back(e_stuck);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        drain(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/truth_table_checker.md
# truth_table_checker

Synthesizable stimulus/response checker for the 2-input gate modules in the gate guides (NAND-built XOR and relatives). It is the response end of the gate-test flow: it drives the DUT inputs through every minterm in ascending order, samples the DUT output after a settle delay, and compares it against a parameterised expected truth table. It replaces hand-written `$monitor` benches with a self-checking pass/fail result usable on hardware.

## Interface
Parameters:
- `N_IN`, 2: number of DUT inputs (1..4); number of minterms `M = 2**N_IN`.
- `EXPECT`, 4'b0110: expected truth table, `M` bits; bit m is the expected `s` for minterm m (default XOR).
- `SETTLE`, 1: clock cycles the stimulus is held before sampling (>= 1).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; sampled only in IDLE or DONE.
- `s_in` in 1: DUT output under test.
- `x` out N_IN: stimulus to DUT inputs; bit N_IN-1 is the leftmost truth-table column (`a`).
- `busy` out 1: high in DRIVE or SAMPLE.
- `done` out 1: high in DONE; held until the next accepted `start` or `reset`.
- `pass` out 1: valid while `done`; 1 iff `fail_mask == 0`.
- `fail_mask` out M: bit m set when minterm m mismatched.
- `fail_count` out N_IN+1: number of mismatching minterms (0..M).
- `minterm` out N_IN: index currently applied; last index checked once `done`.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: `x`=0, `busy`=0, `done`=0. `start`=1 -> DRIVE; `minterm`, `wait_cnt`, `fail_mask`, `fail_count` cleared.
- DRIVE: `x`=`minterm`. Each edge: if `wait_cnt == SETTLE-1` -> SAMPLE, else `wait_cnt` += 1.
- SAMPLE: `x`=`minterm`. On the edge, compare `s_in` with `EXPECT[minterm]`. On mismatch, set `fail_mask[minterm]` and increment `fail_count`. If `minterm == M-1` -> DONE; else `minterm` += 1, `wait_cnt`=0, -> DRIVE.
- DONE: `x`=0, `done`=1, `pass` = (`fail_mask`==0). Results hold. `start`=1 clears results and -> DRIVE, exactly as from IDLE.
- `start` in DRIVE/SAMPLE: ignored. The sweep is not restarted.
- `s_in` is sampled only on the SAMPLE edge; its value in other cycles has no effect.
- `minterm` increment never wraps within a sweep; M-1 terminates.

## Timing
- Reset values: state=IDLE, `x`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `fail_count`=0, `minterm`=0.
- Reset wins over `start` in the same cycle. Reset mid-sweep aborts immediately to IDLE with all results cleared.
- Per minterm: SETTLE cycles in DRIVE, then 1 cycle in SAMPLE.
- `done` rises `M*(SETTLE+1)` cycles after the edge that accepted `start`. Defaults: 8 cycles.
- `x` changes only on the DRIVE entry edge, so the DUT sees a stable input for SETTLE+1 cycles.
- All outputs are registered or decoded from registered state only; there is no combinational path from `s_in` to any output.

## Configuration
- `TT_CHECKER_STOP_ON_FAIL_EN` defined:
  - The first mismatch in SAMPLE goes directly to DONE.
  - `fail_mask` has exactly one bit set, `fail_count`=1, and `minterm` holds the failing index.
  - A fully passing sweep behaves as in the default build.
- Not defined (default): the sweep always covers all M minterms and reports every mismatch.

## Test plan
- Correct XOR DUT (`s_in = x[1]^x[0]`), defaults, pulse `start` -> `x` sequence 0,1,2,3 with each value held 2 cycles; `done`=1 8 cycles after `start`; `pass`=1, `fail_mask`=0000, `fail_count`=0.
- Faulty DUT `s_in = ~x[1] & x[0]` (expected 0110, actual 0010) -> `pass`=0, `fail_mask`=0100, `fail_count`=1, `minterm`=3.
- DUT with `s_in` stuck at 1, `SETTLE`=3 -> `done` after 16 cycles, `fail_mask`=1001, `fail_count`=2. With `TT_CHECKER_STOP_ON_FAIL_EN`: `done` after 4 cycles, `fail_mask`=0001, `minterm`=0.
- Assert `start` again while `busy` (cycle 3 of a sweep) -> sweep is unaffected and `done` still rises at cycle 8. Assert `start` in DONE -> results clear the next cycle and a new sweep runs.
- `reset` at cycle 5 of a failing sweep -> next cycle IDLE, all outputs at their reset values. A following `start` gives a complete, correct result.
- Simultaneous `reset` and `start` in IDLE -> remains in IDLE, `busy`=0.
